// File: rtl/ex_muldiv.sv
`default_nettype none
// ex_muldiv: iterative RV64M multiply/divide unit (radix-2 shift-add / restoring divide).
// The first iteration is folded into the accept edge, so BUSY lasts ITER-1 cycles.
module ex_muldiv #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [TAGW-1:0] in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_rd,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_next;

  logic [2:0]      r_funct3;
  logic            r_word;
  logic [TAGW-1:0] r_rd;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [6:0]      r_cnt;
  logic [63:0]     r_hi, r_lo, r_opd, r_res;

  logic            w_idle, w_accept, w_is_div, w_sgn1, w_sgn2;
  logic [63:0]     w_a, w_b, w_ma, w_mb;
  logic            w_sa, w_sb, w_div0, w_ovf, w_special;
  logic [63:0]     w_dvd_res, w_spec_res;
  logic [63:0]     w_lo_init, w_opd_init;
  logic            w_s_div;
  logic [63:0]     w_s_hi, w_s_lo, w_s_opd;
  logic [64:0]     w_sum, w_shl;
  logic [63:0]     w_dif;
  logic            w_ge;
  logic [63:0]     w_n_hi, w_n_lo;
  logic [6:0]      w_cnt_inc, w_last;
  logic [127:0]    w_prod, w_prodc;
  logic [63:0]     w_quo, w_quoc, w_remc, w_dsel, w_fix;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && in_valid && !flush;
  assign w_is_div = in_funct3[2];
  assign w_sgn1   = (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                    (in_funct3 == 3'b100) || (in_funct3 == 3'b110);
  assign w_sgn2   = (in_funct3 == 3'b001) || (in_funct3 == 3'b100) || (in_funct3 == 3'b110);

  // Operand preparation: extend W operands, then take magnitudes of signed ones.
  always_comb begin
    w_a = in_src1;
    w_b = in_src2;
    if (in_word) begin
      w_a = w_sgn1 ? {{32{in_src1[31]}}, in_src1[31:0]} : {32'd0, in_src1[31:0]};
      w_b = w_sgn2 ? {{32{in_src2[31]}}, in_src2[31:0]} : {32'd0, in_src2[31:0]};
    end
    w_sa = w_sgn1 && w_a[63];
    w_sb = w_sgn2 && w_b[63];
    w_ma = w_sa ? -w_a : w_a;
    w_mb = w_sb ? -w_b : w_b;
  end

  assign w_div0    = w_is_div && (w_b == 64'd0);
  assign w_ovf     = w_is_div && !in_funct3[0] && (w_b == {64{1'b1}}) &&
                     (w_a == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  assign w_special = w_div0 || w_ovf;
  assign w_dvd_res = in_word ? {{32{in_src1[31]}}, in_src1[31:0]} : in_src1;

  always_comb begin
    w_spec_res = 64'd0;
    if (in_funct3[1]) w_spec_res = w_div0 ? w_dvd_res : 64'd0;
    else              w_spec_res = w_div0 ? {64{1'b1}} : w_dvd_res;
  end

  // W dividends are left-aligned so the restoring step always consumes bit 63.
  assign w_lo_init  = w_is_div ? (in_word ? {w_ma[31:0], 32'd0} : w_ma) : w_mb;
  assign w_opd_init = w_is_div ? w_mb : w_ma;

  always_comb begin
    w_s_div = w_idle ? w_is_div   : r_funct3[2];
    w_s_hi  = w_idle ? 64'd0      : r_hi;
    w_s_lo  = w_idle ? w_lo_init  : r_lo;
    w_s_opd = w_idle ? w_opd_init : r_opd;
    w_sum   = {1'b0, w_s_hi} + (w_s_lo[0] ? {1'b0, w_s_opd} : 65'd0);
    w_shl   = {w_s_hi, w_s_lo[63]};
    w_ge    = (w_shl >= {1'b0, w_s_opd});
    w_dif   = w_shl[63:0] - w_s_opd;
    if (w_s_div) begin
      w_n_hi = w_ge ? w_dif : w_shl[63:0];
      w_n_lo = {w_s_lo[62:0], w_ge};
    end else begin
      w_n_hi = w_sum[64:1];
      w_n_lo = {w_sum[0], w_s_lo[63:1]};
    end
  end

  // Sign correction and W sign-extension applied in FIX.
  always_comb begin
    w_prod  = r_word ? {32'd0, r_hi[31:0], r_lo[63:32], 32'd0} >> 32 : {r_hi, r_lo};
    w_prodc = r_neg_q ? -w_prod : w_prod;
    w_quo   = r_word ? {32'd0, r_lo[31:0]} : r_lo;
    w_quoc  = r_neg_q ? -w_quo : w_quo;
    w_remc  = r_neg_r ? -r_hi : r_hi;
    w_dsel  = r_funct3[1] ? w_remc : w_quoc;
    if (r_funct3[2])
      w_fix = r_word ? {{32{w_dsel[31]}}, w_dsel[31:0]} : w_dsel;
    else if (r_funct3[1:0] == 2'b00)
      w_fix = r_word ? {{32{w_prodc[31]}}, w_prodc[31:0]} : w_prodc[63:0];
    else
      w_fix = w_prodc[127:64];
  end

  assign w_cnt_inc = r_cnt + 7'd1;
  assign w_last    = r_word ? 7'd31 : 7'd63;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_next = w_special ? S_DONE : S_BUSY;
        S_BUSY: if (w_cnt_inc == w_last) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: if (out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_funct3 <= 3'd0;
      r_word   <= 1'b0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= 7'd0;
      r_hi     <= 64'd0;
      r_lo     <= 64'd0;
      r_opd    <= 64'd0;
      r_res    <= 64'd0;
    end else if (w_accept) begin
      r_funct3 <= in_funct3;
      r_word   <= in_word;
      r_rd     <= in_rd;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_cnt    <= 7'd0;
      r_hi     <= w_n_hi;
      r_lo     <= w_n_lo;
      r_opd    <= w_opd_init;
      if (w_special) r_res <= w_spec_res;
    end else if (r_state == S_BUSY) begin
      r_cnt <= w_cnt_inc;
      r_hi  <= w_n_hi;
      r_lo  <= w_n_lo;
    end else if (r_state == S_FIX && !flush) begin
      r_res <= w_fix;
    end
  end

  assign in_ready   = w_idle;
  assign busy       = !w_idle;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_res;
  assign out_rd     = r_rd;

endmodule
`default_nettype wire
